// File: rtl/opamp_seq_pkg.sv
// Shared types and constants for the opamp auto-zero sequencer.
package opamp_seq_pkg;

    localparam int unsigned CH_NUM = 2;

    typedef enum logic [2:0] {
        ST_OFF         = 3'd0,
        ST_BIAS_SETTLE = 3'd1,
        ST_RUN         = 3'd2,
        ST_NOV_PRE     = 3'd3,
        ST_AZ          = 3'd4,
        ST_NOV_POST    = 3'd5
    } state_e;

    localparam state_e RST_STATE  = ST_OFF;
    localparam logic   RST_RR_PTR = 1'b0;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One-hot channel mask for a channel index.
    function automatic logic [CH_NUM-1:0] ch_onehot(input logic idx);
        logic [CH_NUM-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/opamp_az_sequencer_if.sv
// Control/status bundle between the top wrapper and the opamp sequencer.
interface opamp_az_sequencer_if;
    import opamp_seq_pkg::*;

    logic              ena;
    logic [CH_NUM-1:0] ch_req;
    logic              az_en;
    logic              bias_en;
    logic [CH_NUM-1:0] out_conn;
    logic [CH_NUM-1:0] az_sw;
    logic              az_done;
    logic              busy;

    modport master (output ena, ch_req, az_en,
                    input  bias_en, out_conn, az_sw, az_done, busy);
    modport slave  (input  ena, ch_req, az_en,
                    output bias_en, out_conn, az_sw, az_done, busy);
endinterface

// File: rtl/opamp_seq_timer.sv
// Loadable down-counter that saturates at zero, with a zero flag.
module opamp_seq_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_c_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_c_o = (cnt_q == '0);
endmodule

// File: rtl/opamp_az_sequencer.sv
// Bias power-up and round-robin auto-zero sequencer for the two opamp channels.
module opamp_az_sequencer
    import opamp_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned AZ_PERIOD  = 1024,
    parameter int unsigned AZ_CYC     = 16,
    parameter int unsigned NOV_CYC    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    opamp_az_sequencer_if.slave  seq_if
);
    localparam int unsigned TMR_W = $clog2(max3(SETTLE_CYC, AZ_CYC, NOV_CYC) + 1);
    localparam int unsigned PER_W = $clog2(AZ_PERIOD);

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              rr_q, rr_d;
    logic              bias_en_q, az_done_q, busy_q;
    logic [CH_NUM-1:0] az_sw_q;
    logic              done_d;

    logic              tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]  tmr_val;
    logic              per_load, per_dec, per_zero;
    logic              abort_c, tgt_c;
    logic [CH_NUM-1:0] out_conn_c;

    opamp_seq_timer #(.W(TMR_W)) u_tmr (
        .clk(clk), .rst_n(rst_n), .load_i(tmr_load), .load_val_i(tmr_val),
        .dec_i(tmr_dec), .zero_c_o(tmr_zero)
    );

    opamp_seq_timer #(.W(PER_W)) u_per (
        .clk(clk), .rst_n(rst_n), .load_i(per_load), .load_val_i(PER_W'(AZ_PERIOD - 1)),
        .dec_i(per_dec), .zero_c_o(per_zero)
    );

    assign abort_c = !seq_if.ena || (seq_if.ch_req == '0);
    // Round-robin pick: preferred channel if requested, otherwise the other one.
    assign tgt_c   = seq_if.ch_req[rr_q] ? rr_q : ~rr_q;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        per_load = 1'b0;
        per_dec  = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                state_d  = ST_BIAS_SETTLE;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(SETTLE_CYC - 1);
            end
            ST_BIAS_SETTLE: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    state_d  = ST_RUN;
                    per_load = 1'b1;
                end
            end
            ST_RUN: begin
                per_dec = 1'b1;
                if (per_zero) begin
                    if (seq_if.az_en) begin
                        sel_d    = tgt_c;
                        state_d  = ST_NOV_PRE;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(NOV_CYC - 1);
                    end else begin
                        per_load = 1'b1;
                    end
                end
            end
            ST_NOV_PRE, ST_AZ: begin
                tmr_dec = 1'b1;
                if (!seq_if.ch_req[sel_q] || (tmr_zero && (state_q == ST_AZ))) begin
                    state_d  = ST_NOV_POST;
                    done_d   = seq_if.ch_req[sel_q];
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(NOV_CYC - 1);
                end else if (tmr_zero) begin
                    state_d  = ST_AZ;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(AZ_CYC - 1);
                end
            end
            ST_NOV_POST: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    state_d  = ST_RUN;
                    rr_d     = ~sel_q;
                    per_load = 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase
        if (abort_c) begin
            state_d = ST_OFF;
            done_d  = 1'b0;
        end
    end

    // State plus registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            sel_q     <= 1'b0;
            rr_q      <= RST_RR_PTR;
            bias_en_q <= 1'b0;
            az_sw_q   <= '0;
            az_done_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            bias_en_q <= (state_d != ST_OFF);
            az_sw_q   <= (state_d == ST_AZ) ? ch_onehot(sel_d) : '0;
            az_done_q <= done_d;
            busy_q    <= (state_d != ST_OFF) && (state_d != ST_RUN);
        end
    end

    // Output switches follow live ch_req, with the channel under auto-zero held open.
    always_comb begin
        out_conn_c = '0;
        unique case (state_q)
            ST_RUN:                         out_conn_c = seq_if.ch_req;
            ST_NOV_PRE, ST_AZ, ST_NOV_POST: out_conn_c = seq_if.ch_req & ~ch_onehot(sel_q);
            default:                        out_conn_c = '0;
        endcase
    end

    assign seq_if.bias_en  = bias_en_q;
    assign seq_if.out_conn = out_conn_c;
    assign seq_if.az_sw    = az_sw_q;
    assign seq_if.az_done  = az_done_q;
    assign seq_if.busy     = busy_q;
endmodule
